// File: rtl/tl_rx_error_report_ctrl.sv
// Receive-side error reporting stage. Turns per-TLP checker verdicts into
// sticky status, a first-error header log, a queue of UR completion
// requests, and one coalesced error-message request.
module tl_rx_error_report_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_WIDTH  = 10
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 chk_valid,
  input  logic                 ur_error,
  input  logic                 mal_error,
  input  logic                 tlp_non_posted,
  input  logic [15:0]          tlp_req_id,
  input  logic [TAG_WIDTH-1:0] tlp_tag,
  input  logic [2:0]           tlp_tc,
  input  logic [2:0]           tlp_attr,
  input  logic [127:0]         tlp_hdr,
  input  logic                 ur_report_en,
  input  logic                 serr_en,
  input  logic [1:0]           sts_clear,
  input  logic                 log_clear,
  output logic                 cpl_valid,
  input  logic                 cpl_ready,
  output logic [15:0]          cpl_req_id,
  output logic [TAG_WIDTH-1:0] cpl_tag,
  output logic [2:0]           cpl_tc,
  output logic [2:0]           cpl_attr,
  output logic [2:0]           cpl_status,
  output logic                 msg_valid,
  input  logic                 msg_ready,
  output logic [7:0]           msg_code,
  output logic                 sts_ur,
  output logic                 sts_mal,
  output logic                 sts_cpl_ovf,
  output logic                 hdr_log_valid,
  output logic [127:0]         hdr_log
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  ERR_NONFATAL = 8'h31;
  localparam logic [7:0]  ERR_FATAL    = 8'h33;

  typedef struct packed {
    logic [15:0]          req_id;
    logic [TAG_WIDTH-1:0] tag;
    logic [2:0]           tc;
    logic [2:0]           attr;
  } cpl_ent_t;

  typedef enum logic {IDLE, PEND} msg_state_t;

  // Verdict classification: malformed masks UR for the same TLP
  logic is_mal, is_ur, any_err;
  assign is_mal  = chk_valid & mal_error;
  assign is_ur   = chk_valid & ~mal_error & ur_error;
  assign any_err = is_mal | is_ur;

  logic rep_fatal, rep_nonfatal, rep_any;
  assign rep_fatal    = is_mal & serr_en;
  assign rep_nonfatal = is_ur & ur_report_en & serr_en;
  assign rep_any      = rep_fatal | rep_nonfatal;

  // ---------------- status and header log ----------------
  logic         sts_ur_q, sts_mal_q, sts_ovf_q, log_vld_q;
  logic         sts_ur_d, sts_mal_d, sts_ovf_d, log_vld_d;
  logic [127:0] log_q, log_d;
  logic         push_drop;

  // Set beats clear; an error arriving with log_clear re-captures
  always_comb begin
    sts_ur_d  = (sts_ur_q  & ~sts_clear[0]) | is_ur;
    sts_mal_d = (sts_mal_q & ~sts_clear[1]) | is_mal;
    sts_ovf_d = sts_ovf_q | push_drop;
    log_vld_d = log_vld_q;
    log_d     = log_q;
    if (any_err && (!log_vld_q || log_clear)) begin
      log_vld_d = 1'b1;
      log_d     = tlp_hdr;
    end else if (log_clear) begin
      log_vld_d = 1'b0;
    end
  end

  // Status and log registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sts_ur_q  <= 1'b0;
      sts_mal_q <= 1'b0;
      sts_ovf_q <= 1'b0;
      log_vld_q <= 1'b0;
      log_q     <= '0;
    end else begin
      sts_ur_q  <= sts_ur_d;
      sts_mal_q <= sts_mal_d;
      sts_ovf_q <= sts_ovf_d;
      log_vld_q <= log_vld_d;
      log_q     <= log_d;
    end
  end

  // ---------------- UR completion queue ----------------
  cpl_ent_t      mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          push_req, pop, push_ok, fifo_full;
  cpl_ent_t      push_ent, head;

  assign push_req  = is_ur & tlp_non_posted;
  assign pop       = cpl_valid & cpl_ready;
  assign fifo_full = (cnt_q == DEPTH_C);
  // A pop in the same cycle frees the slot, so a push at full still lands
  assign push_ok   = push_req & (~fifo_full | pop);
  assign push_drop = push_req & ~push_ok;
  assign push_ent  = '{req_id: tlp_req_id, tag: tlp_tag, tc: tlp_tc, attr: tlp_attr};

  // Storage is not reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_ent;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

  // Head entry shown directly; zeroed while empty so idle outputs stay 0
  assign cpl_valid  = (cnt_q != '0);
  assign head       = cpl_valid ? mem_q[rd_ptr_q] : '0;
  assign cpl_req_id = head.req_id;
  assign cpl_tag    = head.tag;
  assign cpl_tc     = head.tc;
  assign cpl_attr   = head.attr;
  assign cpl_status = 3'b001;

  // ---------------- coalescing message FSM ----------------
  msg_state_t state_q;
  logic [7:0] code_q;

  // One outstanding message; fatal upgrades a pending non-fatal in place
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      code_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: if (rep_any) begin
          state_q <= PEND;
          code_q  <= rep_fatal ? ERR_FATAL : ERR_NONFATAL;
        end
        PEND: begin
          if (msg_ready) begin
            if (rep_any) code_q <= rep_fatal ? ERR_FATAL : ERR_NONFATAL;
            else         state_q <= IDLE;
          end else if (rep_fatal) begin
            code_q <= ERR_FATAL;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign msg_valid     = (state_q == PEND);
  assign msg_code      = code_q;
  assign sts_ur        = sts_ur_q;
  assign sts_mal       = sts_mal_q;
  assign sts_cpl_ovf   = sts_ovf_q;
  assign hdr_log_valid = log_vld_q;
  assign hdr_log       = log_q;

endmodule

// File: doc/tl_rx_error_report_ctrl.md
Name: tl_rx_error_report_ctrl

Overview:
- Receive-side error reporting stage. Sits directly downstream of the RX write/request error checkers, which supply the unsupported-request and malformed flags.
- Consumes one per-TLP verdict strobe. Updates sticky error status bits and captures the first failing header into a header log.
- Queues Unsupported Request (UR) completion requests for non-posted TLPs toward the TX completion generator.
- Raises one coalesced error-message request toward the TX message path.

Parameters:
- FIFO_DEPTH, 4, depth of the UR completion-request queue; power of 2, minimum 2.
- TAG_WIDTH, 10, width of the TLP tag field.

Ports:
- clk  in  1  block clock.
- arst_n  in  1  asynchronous active-low reset.
- chk_valid  in  1  one-cycle strobe; checker verdict and fields below are valid.
- ur_error  in  1  unsupported-request verdict.
- mal_error  in  1  malformed-TLP verdict.
- tlp_non_posted  in  1  TLP requires a completion.
- tlp_req_id  in  16  requester ID.
- tlp_tag  in  TAG_WIDTH  tag.
- tlp_tc  in  3  traffic class.
- tlp_attr  in  3  attributes.
- tlp_hdr  in  128  full TLP header (DW0 in [127:96]).
- ur_report_en  in  1  config: UR reporting enable.
- serr_en  in  1  config: error message enable.
- sts_clear  in  2  W1C pulse; bit0 clears sts_ur, bit1 clears sts_mal.
- log_clear  in  1  pulse; frees the header log.
- cpl_valid  out  1  UR completion request available.
- cpl_ready  in  1  TX completion generator accepts.
- cpl_req_id  out  16  queued requester ID.
- cpl_tag  out  TAG_WIDTH  queued tag.
- cpl_tc  out  3  queued traffic class.
- cpl_attr  out  3  queued attributes.
- cpl_status  out  3  constant 3'b001 (UR).
- msg_valid  out  1  error message pending.
- msg_ready  in  1  TX message path accepts.
- msg_code  out  8  8'h31 ERR_NONFATAL or 8'h33 ERR_FATAL.
- sts_ur  out  1  sticky UR detected.
- sts_mal  out  1  sticky malformed detected.
- sts_cpl_ovf  out  1  sticky: UR completion dropped, queue full.
- hdr_log_valid  out  1  header log holds a captured header.
- hdr_log  out  128  captured header.

Behaviour:
- Reset: all outputs 0, except cpl_status = 3'b001. Queue empty, message idle.
- Reset asserted mid-operation clears the queue, pending message, status and log immediately.
- Verdict classification on chk_valid:
  - mal_error has priority. TLP is treated as malformed only: no completion, fatal severity.
  - Else ur_error: UR, non-fatal severity.
  - Else no action.
  - Fields are ignored when chk_valid = 0.
- Status update (registered, visible the cycle after chk_valid):
  - sts_mal sets on a malformed TLP.
  - sts_ur sets on a UR TLP, regardless of ur_report_en.
  - Set in the same cycle as the matching sts_clear bit: set wins.
- Header log:
  - On any error with hdr_log_valid = 0, capture tlp_hdr and set hdr_log_valid next cycle.
  - Later errors do not overwrite the log.
  - log_clear deasserts hdr_log_valid. Error and log_clear in the same cycle: capture wins, new header logged.
- Completion queue (UR and tlp_non_posted only):
  - Push {req_id, tag, tc, attr} into the FIFO.
  - cpl_valid = not empty; outputs show the head entry (first-word fall-through, registered storage).
  - Pop on cpl_valid && cpl_ready.
  - Push when full: entry dropped, sts_cpl_ovf sets, existing entries unaffected.
  - Push and pop in the same cycle while full: the pop frees space, so the push is accepted.
  - Pointer and count wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
  - Queueing is independent of ur_report_en and serr_en.
- Message state machine, states IDLE and PEND:
  - IDLE -> PEND on a reportable error: malformed with serr_en, or UR with ur_report_en && serr_en.
  - msg_code is latched from severity on entry: fatal 8'h33, non-fatal 8'h31.
  - In PEND, a new reportable fatal error upgrades msg_code to 8'h33. Non-fatal never downgrades. No second message is queued (coalesce).
  - PEND -> IDLE on msg_valid && msg_ready.
  - Handshake and new error in the same cycle: return to PEND with the new code next cycle.
  - msg_valid = (state == PEND).
- Latency: chk_valid to cpl_valid / msg_valid / status is 1 cycle.
- Valid/ready: once asserted, cpl_valid holds with stable fields and msg_valid holds until accepted.

Test Plan:
- Reset, then UR non-posted (req_id 16'h0100, tag 5, tc 0, attr 0), ur_report_en = 1, serr_en = 1, cpl_ready = 0 -> next cycle: cpl_valid = 1, cpl_tag = 5, cpl_status = 3'b001, sts_ur = 1, msg_valid = 1, msg_code = 8'h31, hdr_log = tlp_hdr.
- 5 UR non-posted TLPs (tags 1–5), cpl_ready = 0, FIFO_DEPTH = 4 -> tags 1–4 queued, sts_cpl_ovf = 1. Raising cpl_ready then pops 1, 2, 3, 4 in order; cpl_valid deasserts after the fourth pop.
- mal_error and ur_error together on a non-posted TLP, serr_en = 1 -> no completion queued, sts_mal = 1, sts_ur = 0, msg_code = 8'h33.
- UR then malformed while msg_ready = 0 -> single pending message, code upgrades 8'h31 → 8'h33. One handshake returns msg_valid to 0.
- Second error after the first log capture -> hdr_log unchanged. log_clear in the same cycle as a third error -> hdr_log = third header, hdr_log_valid = 1.
- sts_clear = 2'b01 in the same cycle as a UR -> sts_ur stays 1. serr_en = 0 -> queue works, msg_valid stays 0. arst_n low with queue non-empty -> cpl_valid = 0 immediately.
